// File: rtl/writefifo.sv
// Gen2 Write payload deserializer. Checks the format, CRC flag and handle, then pushes the
// unmasked data word into the tag data FIFO as two bytes, high byte first.
module writefifo (
    input  logic        readbitclk,
    input  logic        reset,
    input  logic        bitin,
    input  logic        bitvalid,
    input  logic        packetend,
    input  logic        crc_ok,
    input  logic [15:0] handle,
    input  logic [15:0] covercode,
    input  logic        fifo_full,
    output logic [7:0]  fifo_dataout,
    output logic        fifo_push,
    output logic        fifo_start,
    output logic [1:0]  membank,
    output logic [7:0]  wordptr,
    output logic        writedone,
    output logic [1:0]  writeerr
);

    typedef enum logic [3:0] {
        StMb, StWp, StData, StRn, StCrc, StPushHi, StPushLo, StDone, StErr
    } state_e;

    localparam logic [1:0] ErrFormat = 2'b01;
    localparam logic [1:0] ErrCrc    = 2'b10;
    localparam logic [1:0] ErrHandle = 2'b11;

    state_e      state;
    logic [5:0]  bitcnt;
    logic [15:0] data_sr;
    logic [15:0] rn_sr;
    logic [15:0] unmasked;
    logic [5:0]  field_end;
    logic        last_bit;
    logic [5:0]  next_cnt;
    logic [5:0]  crc_seen;

    assign unmasked = data_sr ^ covercode;
    // CRC bits including one arriving in the same cycle as packetend
    assign crc_seen = bitcnt + {5'd0, bitvalid};
    assign last_bit = (bitcnt == field_end);
    assign next_cnt = last_bit ? 6'd0 : bitcnt + 6'd1;

    always_comb begin
        field_end = 6'd15;
        case (state)
            StMb:    field_end = 6'd1;
            StWp:    field_end = 6'd7;
            default: field_end = 6'd15;
        endcase
    end

    always_ff @(posedge readbitclk or posedge reset) begin
        if (reset) begin
            state        <= StMb;
            bitcnt       <= 6'd0;
            data_sr      <= 16'd0;
            rn_sr        <= 16'd0;
            membank      <= 2'd0;
            wordptr      <= 8'd0;
            fifo_dataout <= 8'd0;
            fifo_push    <= 1'b0;
            fifo_start   <= 1'b0;
            writedone    <= 1'b0;
            writeerr     <= 2'd0;
        end else begin
            fifo_push  <= 1'b0;
            fifo_start <= 1'b0;
            unique case (state)
                StMb: begin
                    if (bitvalid) membank <= {membank[0], bitin};
                    if (packetend) begin
                        state    <= StErr;
                        writeerr <= ErrFormat;
                    end else if (bitvalid) begin
                        bitcnt <= next_cnt;
                        if (last_bit) state <= StWp;
                    end
                end
                StWp: begin
                    if (bitvalid) wordptr <= {wordptr[6:0], bitin};
                    // Leading 1 would mean a multi-block EBV, which is not supported
                    if ((bitvalid && bitcnt == 6'd0 && bitin) || packetend) begin
                        state    <= StErr;
                        writeerr <= ErrFormat;
                    end else if (bitvalid) begin
                        bitcnt <= next_cnt;
                        if (last_bit) state <= StData;
                    end
                end
                StData: begin
                    if (bitvalid) data_sr <= {data_sr[14:0], bitin};
                    if (packetend) begin
                        state    <= StErr;
                        writeerr <= ErrFormat;
                    end else if (bitvalid) begin
                        bitcnt <= next_cnt;
                        if (last_bit) state <= StRn;
                    end
                end
                StRn: begin
                    if (bitvalid) rn_sr <= {rn_sr[14:0], bitin};
                    if (packetend) begin
                        state    <= StErr;
                        writeerr <= ErrFormat;
                    end else if (bitvalid) begin
                        bitcnt <= next_cnt;
                        if (last_bit) state <= StCrc;
                    end
                end
                StCrc: begin
                    if ((bitvalid && bitcnt == 6'd16) || (packetend && crc_seen != 6'd16)) begin
                        state    <= StErr;
                        writeerr <= ErrFormat;
                    end else if (packetend && !crc_ok) begin
                        state    <= StErr;
                        writeerr <= ErrCrc;
                    end else if (packetend && rn_sr != handle) begin
                        state    <= StErr;
                        writeerr <= ErrHandle;
                    end else if (packetend) begin
                        state <= StPushHi;
                    end else if (bitvalid) begin
                        bitcnt <= bitcnt + 6'd1;
                    end
                end
                StPushHi: begin
                    if (packetend) begin
                        state    <= StErr;
                        writeerr <= ErrFormat;
                    end else if (!fifo_full) begin
                        fifo_push    <= 1'b1;
                        fifo_start   <= 1'b1;
                        fifo_dataout <= unmasked[15:8];
                        state        <= StPushLo;
                    end
                end
                StPushLo: begin
                    if (packetend) begin
                        state    <= StErr;
                        writeerr <= ErrFormat;
                    end else if (!fifo_full) begin
                        fifo_push    <= 1'b1;
                        fifo_dataout <= unmasked[7:0];
                        writedone    <= 1'b1;
                        state        <= StDone;
                    end
                end
                StDone, StErr: begin
                end
                default: state <= StErr;
            endcase
        end
    end

endmodule

// File: doc/writefifo.md
# writefifo

Receive-side counterpart of the tag's read-response serializer: deserializes the payload of a Gen2 Write command one bit per `readbitclk` edge. It checks the length, the EBV word pointer, the CRC flag and the handle. It removes the cover-code mask from the data word and pushes the two resulting data bytes into the tag data FIFO, high byte first. It sits between the command packet parser and the memory-side FIFO, and handles one command per reset.

## Interface
- No parameters.
- `readbitclk`  in  1  bit clock; rising edge samples all inputs.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `bitin`  in  1  serial payload bit, MSB first, starting with the first bit after the command code.
- `bitvalid`  in  1  `bitin` is sampled on this edge.
- `packetend`  in  1  one-cycle pulse; the last payload bit (the final CRC bit) has been delivered.
- `crc_ok`  in  1  upstream CRC-16 verdict; valid while `packetend`=1.
- `handle`  in  16  current tag RN16 handle.
- `covercode`  in  16  RN16 cover code from the preceding Req_RN.
- `fifo_full`  in  1  FIFO cannot accept a byte this cycle.
- `fifo_dataout`  out  8  byte presented to the FIFO.
- `fifo_push`  out  1  write `fifo_dataout` on this edge.
- `fifo_start`  out  1  marks the first byte of the packet; high together with the first push only.
- `membank`  out  2  received MemBank.
- `wordptr`  out  8  received WordPtr.
- `writedone`  out  1  level; the command was accepted and both bytes were pushed.
- `writeerr`  out  2  sticky error code: 00 none, 01 format, 10 CRC, 11 handle.

## Operation
- Field order: MemBank (2 bits), WordPtr (8 bits, single EBV block), Data (16), RN (16), CRC (16, counted only). Field total is 42 bits; full packet is 58 bits.
- States: MB, WP, DATA, RN, CRC, PUSHHI, PUSHLO, DONE, ERR. Transitions:
  - After reset: MB.
  - Each field state shifts `bitin` into its register and advances on bitvalid when its 6-bit bit counter reaches the field end.
  - WP: if the first WordPtr bit (EBV extension) is 1, set `writeerr`=01 and go to ERR immediately.
  - CRC: counts bits; a 17th bit sets error 01 and goes to ERR.
- `packetend` in any state other than CRC sets error 01 (short packet) and goes to ERR.
- `packetend` in CRC, resolved with priority format > CRC > handle:
  - CRC bit count ≠16 → 01.
  - `crc_ok`=0 → 10.
  - RN ≠ `handle` → 11.
  - Otherwise go to PUSHHI.
- `bitvalid` and `packetend` in the same cycle: the bit is counted first, then `packetend` is evaluated including it.
- Unmasked data = Data XOR `covercode`; it is computed combinationally and held stable during the push states.
- PUSHHI: present the high byte with `fifo_push`=1 and `fifo_start`=1. The push happens on the first edge where `fifo_full`=0; then go to PUSHLO.
- PUSHLO: same with the low byte and `fifo_start`=0; then go to DONE.
- `fifo_push`/`fifo_start` are registered and asserted only in cycles where `fifo_full`=0, so each byte is pushed exactly once.
- DONE: `writedone`=1.
- DONE and ERR are terminal; `bitvalid` and `packetend` are ignored until reset. No FIFO push ever occurs on an error path.
- `membank` and `wordptr` update as bits arrive and are final once WP completes.

## Timing
- Reset values: every output is 0; state MB; all counters and shift registers 0.
- Bit sampling: one bit per `readbitclk` edge with `bitvalid`=1; no throughput restriction.
- Latency with `fifo_full`=0 throughout:
  - edge N (`packetend`): enter PUSHHI;
  - edge N+1: push high byte, with `fifo_start` high;
  - edge N+2: push low byte;
  - `writedone` is high after edge N+2.
- Each `fifo_full` cycle adds one cycle of stall.
- Clock requirement: `readbitclk` keeps running for at least 3 edges after `packetend`, plus any `fifo_full` cycles.
- Reset mid-operation, including mid-push: the block returns immediately to reset values; a partially pushed packet is left for the FIFO owner to discard, using `fifo_start` on the next packet.
- `writeerr` is set on the edge the error is detected and holds until reset.

## Test plan
- Nominal: membank=3, wordptr=0x05, Data=0x486E, covercode=0x1234, RN=handle=0xBEEF, 16 CRC bits, `crc_ok`=1 → pushes 0x5A (with `fifo_start`) then 0x5A on edges N+1 and N+2; `writedone`=1; `writeerr`=00; membank=3; wordptr=0x05.
- Backpressure: the nominal packet with `fifo_full`=1 for 3 cycles after `packetend` → exactly 2 pushes, 0x5A/0x5A, the first on edge N+4; no duplicate push.
- Handle mismatch: RN=0xBEEE → `writeerr`=11, no push, `writedone`=0. The same packet with `crc_ok`=0 as well → `writeerr`=10.
- Format: EBV bit=1 → `writeerr`=01 after the first WordPtr bit. `packetend` after 30 bits → 01. 17 CRC bits → 01. None of these pushes.
- Same-cycle and terminal: the last CRC bit arrives with `packetend` in the same cycle → accepted. Further `bitvalid` pulses in DONE change nothing.
- Reset mid-push: assert `reset` between the high and low pushes → all outputs 0 immediately; a following nominal packet completes normally.
